euler_step_seq: RTL



---
 rtl/euler_step_seq_pkg.sv | 28 ++
 rtl/euler_step_seq_if.sv | 13 +
 rtl/euler_update_unit.sv | 79 +++++++
 rtl/euler_step_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/euler_step_seq_pkg.sv
// Shared types, default widths and helper functions for the Euler step sequencer.
package euler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_FRAC_BITS = 8;

  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // A run needs at least one row, no more rows than a bank holds, and one step.
  function automatic logic cfg_ok(input int rows, input int steps, input int depth);
    return (rows != 0) && (rows <= depth) && (steps != 0);
  endfunction

endpackage

// File: rtl/euler_step_seq_if.sv
// Row-result handshake between the A*x / B*u dot-product pipelines and the sequencer.
interface euler_step_seq_if #(
  parameter int DATA_SIZE = euler_pkg::DEF_DATA_SIZE
);
  logic                 ax_valid;
  logic [DATA_SIZE-1:0] ax_data;
  logic                 bu_valid;
  logic [DATA_SIZE-1:0] bu_data;
  logic                 in_ready;

  modport master (output ax_valid, ax_data, bu_valid, bu_data, input in_ready);
  modport slave  (input ax_valid, ax_data, bu_valid, bu_data, output in_ready);
endinterface

// File: rtl/euler_update_unit.sv
// Two-stage x + h*(ax+bu) datapath with range check.
// EULER_SATURATE_EN: clamp out-of-range results instead of only flagging them.
module euler_update_unit
  import euler_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int DIM_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        valid_i,
  input  logic [DIM_W-1:0]            idx_i,
  input  logic signed [DATA_SIZE-1:0] ax_i,
  input  logic signed [DATA_SIZE-1:0] bu_i,
  input  logic signed [DATA_SIZE-1:0] x_i,
  input  logic signed [DATA_SIZE-1:0] h_i,
  output logic                        valid_o,
  output logic                        ovf_o,
  output logic [DIM_W-1:0]            idx_o,
  output logic [DATA_SIZE-1:0]        data_o
);

  localparam int PW = 2 * DATA_SIZE + 1;
  localparam int YW = PW + 1;
  localparam logic signed [YW-1:0] MAXV = YW'(smax(DATA_SIZE));
  localparam logic signed [YW-1:0] MINV = YW'(smin(DATA_SIZE));

  logic signed [DATA_SIZE:0] sum_d;
  logic signed [PW-1:0]      prod_d;
  logic signed [PW-1:0]      prod_q;
  logic signed [PW-1:0]      shift_d;
  logic signed [YW-1:0]      y_d;
  logic [DATA_SIZE-1:0]      x_q;
  logic [DATA_SIZE-1:0]      data_d;
  logic [DIM_W-1:0]          idx1_q;
  logic                      valid1_q;
  logic                      ovf_d;

  always_comb begin
    sum_d   = {ax_i[DATA_SIZE-1], ax_i} + {bu_i[DATA_SIZE-1], bu_i};
    prod_d  = PW'(h_i) * PW'(sum_d);
    shift_d = prod_q >>> FRAC_BITS;
    y_d     = YW'(shift_d) + YW'($signed(x_q));
    ovf_d   = (y_d > MAXV) || (y_d < MINV);
    data_d  = y_d[DATA_SIZE-1:0];
`ifdef EULER_SATURATE_EN
    if (y_d > MAXV) begin
      data_d = MAXV[DATA_SIZE-1:0];
    end else if (y_d < MINV) begin
      data_d = MINV[DATA_SIZE-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      valid1_q <= 1'b0;
      idx1_q   <= '0;
      x_q      <= '0;
      prod_q   <= '0;
      valid_o  <= 1'b0;
      ovf_o    <= 1'b0;
      idx_o    <= '0;
      data_o   <= '0;
    end else begin
      valid1_q <= valid_i;
      idx1_q   <= idx_i;
      x_q      <= x_i;
      prod_q   <= prod_d;
      valid_o  <= valid1_q;
      ovf_o    <= valid1_q & ovf_d;
      idx_o    <= idx1_q;
      data_o   <= data_d;
    end
  end

endmodule

// File: rtl/euler_step_seq.sv
// Multi-step Euler sequencer: FSM, row/step counters and double-buffered state banks.
// EULER_SATURATE_EN: overflow clamps and sets sat_flag instead of aborting the run.
module euler_step_seq
  import euler_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int DIM_W     = 6,
  parameter int DEPTH     = 32,
  parameter int STEP_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] h_step,
  input  logic [DIM_W-1:0]     n_rows,
  input  logic [STEP_W-1:0]    n_steps,
  input  logic                 x_load_valid,
  input  logic [DIM_W-1:0]     x_load_idx,
  input  logic [DATA_SIZE-1:0] x_load_data,
  euler_step_seq_if.slave      pipe,
  input  logic [DIM_W-1:0]     x_rd_addr,
  output logic [DATA_SIZE-1:0] x_rd_data,
  output logic                 step_start,
  output logic                 x_out_valid,
  output logic [DIM_W-1:0]     x_out_idx,
  output logic [DATA_SIZE-1:0] x_out_data,
  output logic                 step_done,
  output logic [STEP_W-1:0]    step_count,
  output logic                 busy,
  output logic                 finish,
`ifdef EULER_SATURATE_EN
  output logic                 sat_flag,
`endif
  output logic                 error
);

  localparam int AW = $clog2(DEPTH);

  state_e               state_q;
  logic                 cur_q;
  logic [DIM_W-1:0]     row_q;
  logic [DIM_W-1:0]     nrows_q;
  logic [STEP_W-1:0]    nsteps_q;
  logic [STEP_W-1:0]    count_q;
  logic [DATA_SIZE-1:0] h_q;
  logic                 step_start_q, step_done_q, busy_q, finish_q, error_q;
  logic [DATA_SIZE-1:0] mem [0:1][0:DEPTH-1];

  logic                 u_valid, u_ovf;
  logic [DIM_W-1:0]     u_idx;
  logic [DATA_SIZE-1:0] u_data;
  logic                 active, abort, accept, we, lastWrite, loadWe;
  logic [STEP_W-1:0]    countNext_d;
  logic [DATA_SIZE-1:0] xCur;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
`ifdef EULER_SATURATE_EN
  assign abort = 1'b0;
`else
  assign abort = active && u_valid && u_ovf;
`endif
  assign pipe.in_ready = (state_q == ST_RUN) && !abort;
  assign accept        = pipe.ax_valid && pipe.bu_valid && pipe.in_ready;
  assign we            = rst && active && u_valid && !abort;
  assign lastWrite     = we && (u_idx == nrows_q - DIM_W'(1));
  assign loadWe        = rst && x_load_valid && (int'(x_load_idx) < DEPTH) &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign countNext_d   = count_q + STEP_W'(1);
  assign xCur          = mem[cur_q][row_q[AW-1:0]];

  // Pipelines always see bank cur; results land in the other bank until the step commits.
  assign x_rd_data   = (rst && (int'(x_rd_addr) < DEPTH)) ? mem[cur_q][x_rd_addr[AW-1:0]] : '0;
  assign x_out_valid = active && u_valid && !abort;
  assign x_out_idx   = u_idx;
  assign x_out_data  = u_data;
  assign step_start  = step_start_q;
  assign step_done   = step_done_q;
  assign step_count  = count_q;
  assign busy        = busy_q;
  assign finish      = finish_q;
  assign error       = error_q;

  euler_update_unit #(
    .DATA_SIZE(DATA_SIZE),
    .FRAC_BITS(FRAC_BITS),
    .DIM_W    (DIM_W)
  ) u_update (
    .clk    (clk),
    .rst    (rst),
    .flush_i(abort),
    .valid_i(accept),
    .idx_i  (row_q),
    .ax_i   (pipe.ax_data),
    .bu_i   (pipe.bu_data),
    .x_i    (xCur),
    .h_i    (h_q),
    .valid_o(u_valid),
    .ovf_o  (u_ovf),
    .idx_o  (u_idx),
    .data_o (u_data)
  );

  always_ff @(posedge clk) begin
    if (we) begin
      mem[~cur_q][u_idx[AW-1:0]] <= u_data;
    end
    if (loadWe) begin
      mem[cur_q][x_load_idx[AW-1:0]] <= x_load_data;
    end
  end

`ifdef EULER_SATURATE_EN
  logic sat_q;
  assign sat_flag = sat_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= 1'b0;
      row_q        <= '0;
      nrows_q      <= '0;
      nsteps_q     <= '0;
      count_q      <= '0;
      h_q          <= '0;
      step_start_q <= 1'b0;
      step_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      error_q      <= 1'b0;
`ifdef EULER_SATURATE_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      step_start_q <= 1'b0;
      step_done_q  <= 1'b0;
`ifdef EULER_SATURATE_EN
      if (active && u_valid && u_ovf) sat_q <= 1'b1;
`endif
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
`ifdef EULER_SATURATE_EN
            sat_q <= 1'b0;
`endif
            if (cfg_ok(int'(n_rows), int'(n_steps), DEPTH)) begin
              h_q          <= h_step;
              nrows_q      <= n_rows;
              nsteps_q     <= n_steps;
              count_q      <= '0;
              finish_q     <= 1'b0;
              error_q      <= 1'b0;
              busy_q       <= 1'b1;
              step_start_q <= 1'b1;
              state_q      <= ST_LAUNCH;
            end else begin
              finish_q <= 1'b1;
              error_q  <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_LAUNCH: begin
          row_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            row_q <= row_q + DIM_W'(1);
            if (row_q == nrows_q - DIM_W'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (lastWrite) begin
            step_done_q <= 1'b1;
            count_q     <= countNext_d;
            cur_q       <= ~cur_q;
            if (countNext_d == nsteps_q) begin
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              step_start_q <= 1'b1;
              state_q      <= ST_LAUNCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // An out-of-range result ends the run without committing the partial bank.
      if (abort) begin
        finish_q <= 1'b1;
        error_q  <= 1'b1;
        busy_q   <= 1'b0;
        state_q  <= ST_DONE;
      end
    end
  end

endmodule
